// File: rtl/data_memory_responder.sv
// Memory-side responder for the multicycle RISC-V datapath: latched request, programmable wait, lane/extend/misalign handling.
// Optional access counters (RdCount/WrCount) are built when DMEM_ACCESS_COUNT_EN is defined.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MisalignErr
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] RdCount,
  output logic [15:0] WrCount
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_f3;
  logic          r_is_wr;
  logic [31:0]   r_rdata, w_rdata_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_err, w_err_nxt;
  logic          w_latch;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_word, w_load, w_wlane;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [3:0]    w_be;
  logic          w_is_byte, w_is_half, w_is_word, w_misalign, w_mem_we;
  logic          w_unused_addr;

  // Address bits above the word index alias onto the same storage.
  assign w_unused_addr = ^Addr[31:AW+2];

  assign w_idx      = r_addr[AW+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_is_byte  = (r_f3[1:0] == 2'b00);
  assign w_is_half  = (r_f3[1:0] == 2'b01);
  assign w_is_word  = r_f3[1];
  assign w_misalign = (w_is_half & r_addr[0]) | (w_is_word & (r_addr[1:0] != 2'b00));
  assign w_mem_we   = (r_state == S_RESP) & r_is_wr & ~w_misalign;

  assign ReadData    = r_rdata;
  assign MemReady    = r_ready;
  assign MisalignErr = r_err;

  // Load path: select lane, shift to bit 0, extend.
  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
    if (w_is_byte)      w_load = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
    else if (w_is_half) w_load = {{16{~r_f3[2] & w_half[15]}}, w_half};
    else                w_load = w_word;
  end

  // Store path: replicate data across lanes, enable only the addressed ones.
  always_comb begin
    w_wlane = r_wdata;
    w_be    = 4'b1111;
    if (w_is_byte) begin
      w_wlane = {4{r_wdata[7:0]}};
      w_be    = 4'b0001 << r_addr[1:0];
    end else if (w_is_half) begin
      w_wlane = {2{r_wdata[15:0]}};
      w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_rdata_nxt = r_rdata;
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemRead | MemWrite) begin
          w_latch = 1'b1;
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
        w_err_nxt   = w_misalign;
        if (!r_is_wr) w_rdata_nxt = w_misalign ? 32'h0 : w_load;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_is_wr <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdata <= w_rdata_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      if (w_latch) begin
        r_addr  <= Addr[AW+1:0];
        r_wdata <= WriteData;
        r_f3    <= Funct3;
        r_is_wr <= MemWrite;
      end
    end
  end

  // Storage is not reset; contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_we && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;
  logic        w_cnt_ok;

  assign w_cnt_ok = (r_state == S_RESP) & ~w_misalign;
  assign RdCount  = r_rd_cnt;
  assign WrCount  = r_wr_cnt;

  // Saturating counters of completed aligned accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_cnt_ok && !r_is_wr && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_cnt_ok &&  r_is_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_data_memory_responder;

  logic        clk;
  logic        rst;
  logic        mem_rd, mem_wr, rd0, wr0;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_f3;
  logic [31:0] rdata1, rdata0;
  logic        rdy1, rdy0, err1, err0;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rdc1, wrc1, rdc0, wrc0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .MemRead(mem_rd), .MemWrite(mem_wr), .Addr(a_addr),
    .WriteData(a_wdata), .Funct3(a_f3), .ReadData(rdata1), .MemReady(rdy1), .MisalignErr(err1)
`ifdef DMEM_ACCESS_COUNT_EN
    , .RdCount(rdc1), .WrCount(wrc1)
`endif
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .Addr(a_addr),
    .WriteData(a_wdata), .Funct3(a_f3), .ReadData(rdata0), .MemReady(rdy0), .MisalignErr(err0)
`ifdef DMEM_ACCESS_COUNT_EN
    , .RdCount(rdc0), .WrCount(wrc0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One request: held for a single sampling edge, then inputs scrambled to prove they were latched.
  task automatic access(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int   n;
    logic got;
    @(negedge clk);
    if (sel) begin rd0 = rd; wr0 = wr; end
    else     begin mem_rd = rd; mem_wr = wr; end
    a_addr = addr; a_wdata = wdata; a_f3 = f3;
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    a_addr = ~addr; a_wdata = ~wdata; a_f3 = 3'b010;
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      got = sel ? rdy0 : rdy1;
    end
    check($sformatf("%s.ready", tag), 32'(got), 32'd1);
    check($sformatf("%s.latency", tag), 32'(n), sel ? 32'd2 : 32'd3);
    check($sformatf("%s.rdata", tag), sel ? rdata0 : rdata1, exp_rd);
    check($sformatf("%s.err", tag), 32'(sel ? err0 : err1), 32'(exp_err));
    @(negedge clk);
    check($sformatf("%s.pulse", tag), 32'(sel ? rdy0 : rdy1), 32'd0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,  32'h11223344, 3'b010, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h13,  32'h00000080, 3'b000, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 32'h80223344, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h13,  32'h0,        3'b100, 32'h00000080, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFF8022, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h12,  32'h0,        3'b101, 32'h00008022, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h10,  32'hABCD7FFF, 3'b001, 32'h00008022, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        3'b001, 32'h00007FFF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h410, 32'h0,        3'b010, 32'h80227FFF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h20,  32'h00000000, 3'b010, 32'h80227FFF, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h21,  32'hFFFFFFFF, 3'b010, 32'h80227FFF, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 32'h10,  32'h0,        3'b010, 32'h80227FFF, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h11,  32'h0,        3'b001, 32'h00000000, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 32'h00000000, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 32'h12,  32'h0,        3'b101, 32'h00008022, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 32'h12,  32'h0,        3'b010, 32'h00000000, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 32'h23,  32'h0000FFFF, 3'b001, 32'h00000000, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 32'h21,  32'h000000A5, 3'b000, 32'h00000000, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 32'h21,  32'h0,        3'b000, 32'hFFFFFFA5, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 32'h20,  32'h0,        3'b011, 32'h0000A500, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 32'h21,  32'h0,        3'b110, 32'h00000000, 1'b1};
    vecs[24] = '{1'b1, 1'b1, 32'h20,  32'h12345678, 3'b010, 32'h00000000, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 32'h12345678, 1'b0};
    vecs[26] = '{1'b1, 1'b0, 32'h22,  32'h0,        3'b101, 32'h00001234, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 32'h20,  32'h0,        3'b000, 32'h00000078, 1'b0};

    clk = 1'b0; rst = 1'b1;
    mem_rd = 1'b0; mem_wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    a_addr = '0; a_wdata = '0; a_f3 = '0;
    #2 rst = 1'b0;
    #1;
    check("rst.rdata", rdata1, 32'h0);
    check("rst.ready", 32'(rdy1), 32'd0);
    check("rst.err", 32'(err1), 32'd0);
    check("rst.rdata0", rdata0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
             vecs[i].exp_rd, vecs[i].exp_err, $sformatf("v%0d", i));

    // Zero-wait instance: single access, then a held read that must repeat every other cycle.
    access(1'b1, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, "ws0.sw");
    @(negedge clk);
    rd0 = 1'b1; a_addr = 32'h30; a_f3 = 3'b010;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("ws0.held%0d", j), 32'(rdy0), 32'(j % 2));
    end
    rd0 = 1'b0;
    check("ws0.held.rdata", rdata0, 32'hCAFEF00D);
    @(negedge clk);
    check("ws0.held.idle", 32'(rdy0), 32'd0);

    // Reset during WAIT aborts the pending write.
    access(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 3'b010, 32'h00000078, 1'b0, "pre40");
    @(negedge clk);
    mem_wr = 1'b1; a_addr = 32'h40; a_wdata = 32'h55; a_f3 = 3'b010;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst.rdata", rdata1, 32'h0);
    check("midrst.ready", 32'(rdy1), 32'd0);
    check("midrst.err", 32'(err1), 32'd0);
    check("midrst.rdata0", rdata0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (rdy1) pulses++;
    end
    check("midrst.no_ready", 32'(pulses), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h00000000, 1'b0, "post.lw40");
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h80227FFF, 1'b0, "post.lw10");
    access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h00000000, 1'b0, "post.lw40b");
    access(1'b0, 1'b0, 1'b1, 32'h50, 32'h1, 3'b010, 32'h00000000, 1'b0, "cnt.sw50");
    access(1'b0, 1'b0, 1'b1, 32'h54, 32'h2, 3'b010, 32'h00000000, 1'b0, "cnt.sw54");
    access(1'b0, 1'b0, 1'b1, 32'h51, 32'h3, 3'b010, 32'h00000000, 1'b1, "cnt.sw51");
`ifdef DMEM_ACCESS_COUNT_EN
    check("cnt.rd", 32'(rdc1), 32'd3);
    check("cnt.wr", 32'(wrc1), 32'd2);
    check("cnt.rd0", 32'(rdc0), 32'd0);
    check("cnt.wr0", 32'(wrc0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
